// File: rtl/slave_tx_arb_pkg.sv
// slave_tx_arb_pkg
// Shared definitions for the slave return-line arbiter: the FSM state
// encoding and the default response word width.
package slave_tx_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational rotating-priority picker. Scans req starting at ptr,
// then ptr+1, ... wrapping at NUM_SLAVES, and reports the first set index.
// With ptr held at 0 it degenerates into lowest-index fixed priority.
// Ports:
//   req    [NUM_SLAVES-1:0]  request vector
//   ptr    [PTR_W-1:0]       index with highest priority (must be < NUM_SLAVES)
//   any                      at least one request present
//   winner [PTR_W-1:0]       index of the selected request (0 when none)
//   onehot [NUM_SLAVES-1:0]  one-hot form of winner (0 when none)
module rr_arbiter #(
  parameter int NUM_SLAVES = 3,
  parameter int PTR_W      = $clog2(NUM_SLAVES)
) (
  input  logic [NUM_SLAVES-1:0] req,
  input  logic [PTR_W-1:0]      ptr,
  output logic                  any,
  output logic [PTR_W-1:0]      winner,
  output logic [NUM_SLAVES-1:0] onehot
);

  // Rotating scan; the first hit locks the winner, later hits are ignored.
  always_comb begin
    int  idx;
    logic hit;
    idx    = 0;
    hit    = 1'b0;
    any    = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      idx    = int'(ptr) + i;
      idx    = (idx >= NUM_SLAVES) ? (idx - NUM_SLAVES) : idx;
      hit    = req[idx] & ~any;
      winner = hit ? PTR_W'(idx) : winner;
      any    = any | req[idx];
    end
    onehot = any ? (NUM_SLAVES'(1'b1) << winner) : '0;
  end

endmodule

// File: rtl/slave_tx_arbiter.sv
// slave_tx_arbiter
// Shares the single serial return line to the master between NUM_SLAVES
// response sources. An arbitration pass picks one pending byte, latches it
// and shifts it out LSB first; master_ready low pauses the shift for a cycle.
// Build option: define SLAVE_TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority (no rotating pointer); default is round-robin.
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-low reset
//   master_ready  master accepts a bit this cycle
//   slave_valid   per-slave byte pending
//   slave_data    slave i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   slave_ack     one-cycle pulse: byte of slave i captured
//   grant         one-hot owner of the line during a transfer
//   busy          transfer in progress
//   tx_data       serial bit, LSB first
//   tx_valid      tx_data holds a valid bit
//   tx_done       one-cycle pulse after the last bit
module slave_tx_arbiter
  import slave_tx_arb_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PTR_W      = $clog2(NUM_SLAVES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             master_ready,
  input  logic [NUM_SLAVES-1:0]            slave_valid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_data,
  output logic [NUM_SLAVES-1:0]            slave_ack,
  output logic [NUM_SLAVES-1:0]            grant,
  output logic                             busy,
  output logic                             tx_data,
  output logic                             tx_valid,
  output logic                             tx_done
);

  localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state_r, state_next_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_next_s;
  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic [NUM_SLAVES-1:0]   ack_r, ack_next_s;
  logic [NUM_SLAVES-1:0]   grant_r, grant_next_s;
  logic                    busy_r, busy_next_s;
  logic                    tx_data_r, tx_data_next_s;
  logic                    tx_valid_r, tx_valid_next_s;
  logic                    tx_done_r, tx_done_next_s;

  logic                    arb_any_s;
  logic [PTR_W-1:0]        arb_idx_s;
  logic [NUM_SLAVES-1:0]   arb_onehot_s;
  logic [PTR_W-1:0]        ptr_s;
  logic                    accept_s;

  rr_arbiter #(
    .NUM_SLAVES (NUM_SLAVES),
    .PTR_W      (PTR_W)
  ) u_arb (
    .req    (slave_valid),
    .ptr    (ptr_s),
    .any    (arb_any_s),
    .winner (arb_idx_s),
    .onehot (arb_onehot_s)
  );

  assign accept_s = master_ready & arb_any_s;

`ifdef SLAVE_TX_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_r;

  // Remember the owner so the pointer can step just past it once its byte is out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r <= '0;
      win_r <= '0;
    end else begin
      if (state_r == IDLE && accept_s) begin
        win_r <= arb_idx_s;
      end
      if (state_r == DONE) begin
        ptr_r <= (win_r == PTR_W'(NUM_SLAVES - 1)) ? '0 : (win_r + PTR_W'(1));
      end
    end
  end

  assign ptr_s = ptr_r;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      cnt_r      <= '0;
      ack_r      <= '0;
      grant_r    <= '0;
      busy_r     <= 1'b0;
      tx_data_r  <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      shift_r    <= shift_next_s;
      cnt_r      <= cnt_next_s;
      ack_r      <= ack_next_s;
      grant_r    <= grant_next_s;
      busy_r     <= busy_next_s;
      tx_data_r  <= tx_data_next_s;
      tx_valid_r <= tx_valid_next_s;
      tx_done_r  <= tx_done_next_s;
    end
  end

  // Next-state and next-output logic; pulses (ack, valid, done) default low.
  always_comb begin
    state_next_s    = state_r;
    shift_next_s    = shift_r;
    cnt_next_s      = cnt_r;
    ack_next_s      = '0;
    grant_next_s    = grant_r;
    busy_next_s     = busy_r;
    tx_data_next_s  = tx_data_r;
    tx_valid_next_s = 1'b0;
    tx_done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_next_s   = slave_data[int'(arb_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          cnt_next_s     = '0;
          ack_next_s     = arb_onehot_s;
          grant_next_s   = arb_onehot_s;
          busy_next_s    = 1'b1;
          tx_data_next_s = 1'b0;
          state_next_s   = SHIFT;
        end else begin
          grant_next_s   = '0;
          busy_next_s    = 1'b0;
          tx_data_next_s = 1'b0;
        end
      end
      SHIFT: begin
        // master_ready low holds shift, counter and the last driven bit.
        if (master_ready) begin
          tx_data_next_s  = shift_r[0];
          tx_valid_next_s = 1'b1;
          shift_next_s    = shift_r >> 1;
          cnt_next_s      = cnt_r + CNT_W'(1);
          state_next_s    = (cnt_r == LAST_BIT) ? DONE : SHIFT;
        end else begin
          tx_valid_next_s = 1'b0;
        end
      end
      DONE: begin
        tx_done_next_s = 1'b1;
        grant_next_s   = '0;
        busy_next_s    = 1'b0;
        tx_data_next_s = 1'b0;
        state_next_s   = IDLE;
      end
      default: begin
        state_next_s   = IDLE;
        grant_next_s   = '0;
        busy_next_s    = 1'b0;
        tx_data_next_s = 1'b0;
      end
    endcase
  end

  assign slave_ack = ack_r;
  assign grant     = grant_r;
  assign busy      = busy_r;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// tb_slave_tx_arbiter
// Self-checking bench for slave_tx_arbiter (NUM_SLAVES=3, DATA_WIDTH=8).
// Slave models serve bytes from per-slave FIFOs; each expected (owner, byte)
// is pushed to a scoreboard when queued and compared when tx_done is seen.
// Follows SLAVE_TX_ARB_FIXED_PRIO_EN to pick the expected winner order.
module tb_slave_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            master_ready;
  logic [N-1:0]    slave_valid;
  logic [N*DW-1:0] slave_data;
  logic [N-1:0]    slave_ack;
  logic [N-1:0]    grant;
  logic            busy;
  logic            tx_data;
  logic            tx_valid;
  logic            tx_done;

  slave_tx_arbiter #(.NUM_SLAVES(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .master_ready (master_ready),
    .slave_valid  (slave_valid),
    .slave_data   (slave_data),
    .slave_ack    (slave_ack),
    .grant        (grant),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] slave;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] smem [N][16];
  int         head [N];
  int         tail [N];
  int         n_checks = 0;
  int         n_pass   = 0;

  int         nbits    = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [N-1:0] prev_ack = '0;
  logic [N-1:0] owner    = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic enqueue(input int s, input logic [7:0] d, input bit expect_it);
    exp_t e;
    smem[s][tail[s]] = d;
    tail[s]++;
    if (expect_it) begin
      e.slave = 2'(s);
      e.data  = d;
      sb.push_back(e);
    end
  endtask

  task automatic wait_ack(input string tag, input logic [N-1:0] exp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (slave_ack != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) chk(tag, 32'(slave_ack), 32'(exp));
    else chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Monitor + slave models on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      nbits    = 0;
      cur_byte = 8'h00;
      prev_ack = '0;
    end else begin
      if (prev_ack != '0) chk("ack_pulse", 32'(slave_ack), 32'd0);
      if (slave_ack != '0) begin
        chk("grant_eq_ack", 32'(grant), 32'(slave_ack));
        owner = slave_ack;
      end
      if (tx_valid) begin
        if (nbits < 8) cur_byte[nbits] = tx_data;
        nbits++;
      end
      if (tx_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("byte", 32'(cur_byte), 32'(e.data));
          chk("owner", 32'(owner), 32'd1 << e.slave);
          chk("nbits", 32'(nbits), 32'd8);
        end
        nbits    = 0;
        cur_byte = 8'h00;
      end
      prev_ack = slave_ack;
    end
    for (int i = 0; i < N; i++) begin
      if (reset && slave_ack[i] && head[i] < tail[i]) head[i]++;
      slave_valid[i]        = (head[i] < tail[i]);
      slave_data[i*DW +: DW] = (head[i] < tail[i]) ? smem[i][head[i]] : 8'h00;
    end
  end

  initial begin
    int done_k;
    int busy_k;
    int vcnt;
    int lowcnt;
    reset        = 1'b0;
    master_ready = 1'b1;

    // Reset with every slave requesting; then first accept and rotation order.
`ifdef SLAVE_TX_ARB_FIXED_PRIO_EN
    enqueue(0, 8'h01, 1'b1);
    enqueue(0, 8'h04, 1'b1);
    enqueue(1, 8'h02, 1'b1);
    enqueue(2, 8'h03, 1'b1);
`else
    enqueue(0, 8'h01, 1'b1);
    enqueue(1, 8'h02, 1'b1);
    enqueue(2, 8'h03, 1'b1);
    enqueue(0, 8'h04, 1'b1);
`endif
    repeat (3) step();
    chk("reset_outs", 32'({slave_ack, grant, busy, tx_data, tx_valid, tx_done}), 32'd0);
    reset = 1'b1;
    wait_ack("first_ack", 3'b001);
    wait_drain("rr");

    // Single byte, no pause: latency of done and busy, bit count.
    enqueue(1, 8'hA5, 1'b1);
    wait_ack("single_ack", 3'b010);
    done_k = -1;
    busy_k = -1;
    vcnt   = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tx_valid) vcnt++;
      if (!busy && busy_k < 0) busy_k = k;
      if (tx_done) begin
        done_k = k;
        break;
      end
    end
    chk("done_latency", 32'(done_k), 32'd9);
    chk("busy_latency", 32'(busy_k), 32'd9);
    chk("valid_count", 32'(vcnt), 32'd8);
    step();
    chk("done_one_cycle", 32'(tx_done), 32'd0);
    wait_drain("single");

    // Back-pressure after bit 2 of 8'h3C; lone requester wins regardless of ptr.
    enqueue(0, 8'h3C, 1'b1);
    wait_ack("bp_ack", 3'b001);
    repeat (3) step();
    chk("bit2_valid", 32'(tx_valid), 32'd1);
    master_ready = 1'b0;
    lowcnt = 0;
    repeat (3) begin
      step();
      if (!tx_valid) lowcnt++;
    end
    chk("pause_low", 32'(lowcnt), 32'd3);
    chk("pause_hold", 32'(tx_data), 32'd1);
    master_ready = 1'b1;
    done_k = -1;
    for (int k = 7; k <= 30; k++) begin
      step();
      if (tx_done) begin
        done_k = k;
        break;
      end
    end
    chk("bp_done_latency", 32'(done_k), 32'd12);
    wait_drain("bp");

    // Reset after bit 4: partial byte dropped, same slave wins on re-request.
    enqueue(2, 8'h5A, 1'b0);
    wait_ack("abort_ack", 3'b100);
    repeat (5) step();
    chk("bit4_valid", 32'(tx_valid), 32'd1);
    reset = 1'b0;
    step();
    chk("abort_outs", 32'({slave_ack, grant, busy, tx_data, tx_valid, tx_done}), 32'd0);
    reset = 1'b1;
    enqueue(2, 8'h5A, 1'b1);
    wait_ack("rereq_ack", 3'b100);
    wait_drain("abort");

    // Slaves 0 and 2 competing: alternation with wrap, or slave 0 first.
`ifdef SLAVE_TX_ARB_FIXED_PRIO_EN
    enqueue(0, 8'hA1, 1'b1);
    enqueue(0, 8'hA2, 1'b1);
    enqueue(0, 8'hA3, 1'b1);
    enqueue(2, 8'hB1, 1'b1);
    enqueue(2, 8'hB2, 1'b1);
`else
    enqueue(0, 8'hA1, 1'b1);
    enqueue(2, 8'hB1, 1'b1);
    enqueue(0, 8'hA2, 1'b1);
    enqueue(2, 8'hB2, 1'b1);
    enqueue(0, 8'hA3, 1'b1);
`endif
    wait_drain("prio");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
